// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the IO bus arbiter and the per-core IO request queues.
package io_bus_arbiter_pkg;

  localparam int MAX_CORES        = 4;
  localparam int CORE_ID_WIDTH    = $clog2(MAX_CORES);
  localparam int THREAD_IDX_WIDTH = 2;

  // Read value returned to the thread when the device never acknowledges.
  localparam logic [31:0] IO_TIMEOUT_DATA = 32'hffffffff;

  typedef logic [CORE_ID_WIDTH-1:0]    core_id_t;
  typedef logic [THREAD_IDX_WIDTH-1:0] thread_idx_t;

  typedef struct packed {
    logic        is_store;
    logic [31:0] address;
    logic [31:0] value;
    thread_idx_t thread_idx;
  } ioreq_packet_t;

  typedef struct packed {
    core_id_t    core;
    thread_idx_t thread_idx;
    logic [31:0] read_value;
  } iorsp_packet_t;

  typedef enum logic [1:0] {
    IO_BUS_IDLE,
    IO_BUS_ACTIVE,
    IO_BUS_RESPOND
  } io_bus_state_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Request/response and device-bus signals of the IO bus arbiter.
// master: the arbiter itself; slave: the request queues plus the IO device.
interface io_bus_arbiter_if
  import io_bus_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4
) ();

  logic [NUM_CORES-1:0] ior_request_valid;
  ioreq_packet_t        ior_request [NUM_CORES];
  logic [NUM_CORES-1:0] ii_ready;
  logic                 ii_response_valid;
  iorsp_packet_t        ii_response;
  logic                 io_write_en;
  logic                 io_read_en;
  logic [31:0]          io_address;
  logic [31:0]          io_write_data;
  logic [31:0]          io_read_data;
  logic                 io_ack;

  modport master (
    input  ior_request_valid, ior_request, io_read_data, io_ack,
    output ii_ready, ii_response_valid, ii_response,
           io_write_en, io_read_en, io_address, io_write_data
  );

  modport slave (
    output ior_request_valid, ior_request, io_read_data, io_ack,
    input  ii_ready, ii_response_valid, ii_response,
           io_write_en, io_read_en, io_address, io_write_data
  );

endinterface

// File: rtl/io_bus_arbiter_arb.sv
// Round-robin arbiter and one-hot to index encoder used by the IO bus arbiter.
module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  logic [IDX_W-1:0] highest;
  int               grant_idx;

  // Scan requesters starting from the current highest-priority slot.
  always_comb begin
    grant_oh  = '0;
    grant_idx = 0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      if (request[(int'(highest) + i) % NUM_REQUESTERS]) begin
        grant_idx = (int'(highest) + i) % NUM_REQUESTERS;
      end
    end
    if (|request) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // The winner drops to lowest priority; the slot after it becomes highest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      highest <= '0;
    end else if (update_lru) begin
      highest <= IDX_W'((grant_idx + 1) % NUM_REQUESTERS);
    end
  end

endmodule

module oh_to_idx #(
  parameter int NUM_SIGNALS = 4,
  localparam int IDX_W = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1
) (
  input  logic [NUM_SIGNALS-1:0] one_hot,
  output logic [IDX_W-1:0]       index
);

  // OR together the positions of set bits; exact for a one-hot input.
  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      if (one_hot[i]) begin
        index = index | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares one non-cacheable IO bus among the per-core IO request queues.
// One transaction outstanding at a time: grant, drive bus until ack or
// timeout, then broadcast a one-cycle response tagged with core/thread.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic              clk,
  input logic              reset,
  io_bus_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  io_bus_state_t        state, state_next;
  logic [NUM_CORES-1:0] grant_oh;
  logic [NUM_CORES-1:0] grant_q;
  logic                 update_lru;
  ioreq_packet_t        req_sel;
  logic                 req_is_store;
  thread_idx_t          req_thread;
  core_id_t             core_idx;
  logic [CNT_W-1:0]     count;
  logic                 timeout;

  assign update_lru = (state == IO_BUS_IDLE) && (|bus.ior_request_valid);
  assign timeout    = (count == CNT_LAST);
  assign bus.ii_ready = (state == IO_BUS_IDLE) ? grant_oh : '0;

  rr_arbiter #(.NUM_REQUESTERS(NUM_CORES)) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .request   (bus.ior_request_valid),
    .update_lru(update_lru),
    .grant_oh  (grant_oh)
  );

  oh_to_idx #(.NUM_SIGNALS(NUM_CORES)) u_oh_to_idx (
    .one_hot(grant_q),
    .index  (core_idx)
  );

  // Select the packet of the granted core.
  always_comb begin
    req_sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_oh[i]) begin
        req_sel = bus.ior_request[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IO_BUS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; ack takes precedence over timeout.
  always_comb begin
    state_next = state;
    case (state)
      IO_BUS_IDLE:    if (|bus.ior_request_valid) state_next = IO_BUS_ACTIVE;
      IO_BUS_ACTIVE:  if (bus.io_ack || timeout)  state_next = IO_BUS_RESPOND;
      IO_BUS_RESPOND: state_next = IO_BUS_IDLE;
      default:        state_next = IO_BUS_IDLE;
    endcase
  end

  // Latched request, registered bus strobes, timeout counter and response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q           <= '0;
      req_is_store      <= 1'b0;
      req_thread        <= '0;
      count             <= '0;
      bus.io_write_en   <= 1'b0;
      bus.io_read_en    <= 1'b0;
      bus.io_address    <= '0;
      bus.io_write_data <= '0;
      bus.ii_response_valid <= 1'b0;
      bus.ii_response   <= '0;
    end else begin
      bus.ii_response_valid <= 1'b0;
      case (state)
        IO_BUS_IDLE: begin
          if (update_lru) begin
            grant_q           <= grant_oh;
            req_is_store      <= req_sel.is_store;
            req_thread        <= req_sel.thread_idx;
            count             <= '0;
            bus.io_write_en   <= req_sel.is_store;
            bus.io_read_en    <= !req_sel.is_store;
            bus.io_address    <= req_sel.address;
            bus.io_write_data <= req_sel.value;
          end
        end
        IO_BUS_ACTIVE: begin
          if (bus.io_ack || timeout) begin
            count                  <= '0;
            bus.io_write_en        <= 1'b0;
            bus.io_read_en         <= 1'b0;
            bus.ii_response_valid  <= 1'b1;
            bus.ii_response.core       <= core_idx;
            bus.ii_response.thread_idx <= req_thread;
            if (bus.io_ack) begin
              bus.ii_response.read_value <= req_is_store ? 32'h0 : bus.io_read_data;
            end else begin
              bus.ii_response.read_value <= IO_TIMEOUT_DATA;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        default: count <= '0;
      endcase
    end
  end

  // A device ack outside a bus transaction is ignored by the FSM; flag it in simulation.
  spurious_ack: assert property (@(posedge clk) disable iff (reset)
    bus.io_ack |-> (state == IO_BUS_ACTIVE))
    else $warning("io_ack seen outside a bus transaction; ignored");

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter (NUM_CORES=4, TIMEOUT_CYCLES=8).
module tb_io_bus_arbiter;
  import io_bus_arbiter_pkg::*;

  logic clk;
  logic reset;
  logic auto_ack;
  logic man_ack;

  io_bus_arbiter_if #(.NUM_CORES(4)) bus_if ();

  io_bus_arbiter #(.NUM_CORES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  assign bus_if.io_ack = auto_ack ? (bus_if.io_read_en | bus_if.io_write_en) : man_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int rd_cycles, wr_cycles, rsp_cnt, multi_ready, overlap, grant_n;
  int grant_log [64];
  iorsp_packet_t last_rsp;

  int rd0, wr0, rsp0, g0;

  // Observe outputs away from the active edge.
  always @(negedge clk) begin
    if (bus_if.io_read_en)  rd_cycles++;
    if (bus_if.io_write_en) wr_cycles++;
    if (bus_if.ii_response_valid) begin
      rsp_cnt++;
      last_rsp = bus_if.ii_response;
    end
    if ($countones(bus_if.ii_ready) > 1) multi_ready++;
    if (|bus_if.ii_ready) begin
      if (bus_if.io_read_en || bus_if.io_write_en || bus_if.ii_response_valid) overlap++;
      for (int k = 0; k < 4; k++) begin
        if (bus_if.ii_ready[k] && grant_n < 64) grant_log[grant_n] = k;
      end
      grant_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int core, input logic st, input logic [31:0] addr,
                         input logic [31:0] val, input logic [1:0] thr);
    bus_if.ior_request[core].is_store   = st;
    bus_if.ior_request[core].address    = addr;
    bus_if.ior_request[core].value      = val;
    bus_if.ior_request[core].thread_idx = thr;
  endtask

  task automatic snap();
    rd0 = rd_cycles; wr0 = wr_cycles; rsp0 = rsp_cnt; g0 = grant_n;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rd_cycles = 0; wr_cycles = 0; rsp_cnt = 0; multi_ready = 0; overlap = 0; grant_n = 0;
    last_rsp = '0;
    auto_ack = 1'b0; man_ack = 1'b0;
    bus_if.ior_request_valid = '0;
    bus_if.io_read_data = '0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h0, 32'h0, 2'd0);

    // Reset state
    reset = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_ready", 32'(bus_if.ii_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus_if.ii_response_valid), 32'h0);
    chk("rst_strobes", {30'h0, bus_if.io_write_en, bus_if.io_read_en}, 32'h0);
    chk("rst_address", bus_if.io_address, 32'h0);
    chk("rst_wdata", bus_if.io_write_data, 32'h0);
    chk("rst_response", 32'(bus_if.ii_response), 32'h0);
    step();
    reset = 1'b0;
    step();

    // Test 1: load core 2 thread 1 @0x100, ack in third strobe cycle
    set_req(2, 1'b0, 32'h100, 32'h0, 2'd1);
    bus_if.ior_request_valid = 4'b0100;
    snap();
    @(negedge clk);
    chk("t1_ready", 32'(bus_if.ii_ready), 32'h4);
    step();
    bus_if.ior_request_valid = '0;
    @(negedge clk);
    chk("t1_read_en", 32'(bus_if.io_read_en), 32'h1);
    chk("t1_write_en", 32'(bus_if.io_write_en), 32'h0);
    chk("t1_address", bus_if.io_address, 32'h100);
    step();
    step();
    man_ack = 1'b1; bus_if.io_read_data = 32'h1234;
    step();
    man_ack = 1'b0; bus_if.io_read_data = 32'h0;
    @(negedge clk);
    chk("t1_rsp_valid", 32'(bus_if.ii_response_valid), 32'h1);
    chk("t1_read_en_off", 32'(bus_if.io_read_en), 32'h0);
    step();
    @(negedge clk);
    chk("t1_rsp_one_cycle", 32'(bus_if.ii_response_valid), 32'h0);
    chk("t1_rd_cycles", 32'(rd_cycles - rd0), 32'd3);
    chk("t1_rsp_count", 32'(rsp_cnt - rsp0), 32'd1);
    chk("t1_rsp_core", 32'(last_rsp.core), 32'd2);
    chk("t1_rsp_thread", 32'(last_rsp.thread_idx), 32'd1);
    chk("t1_rsp_value", last_rsp.read_value, 32'h1234);
    step();

    // Test 2: store core 0 @0x20 = 0xcafe, ack as strobe rises
    set_req(0, 1'b1, 32'h20, 32'hcafe, 2'd2);
    bus_if.ior_request_valid = 4'b0001;
    snap();
    @(negedge clk);
    chk("t2_ready", 32'(bus_if.ii_ready), 32'h1);
    step();
    bus_if.ior_request_valid = '0;
    man_ack = 1'b1;
    @(negedge clk);
    chk("t2_write_en", 32'(bus_if.io_write_en), 32'h1);
    chk("t2_read_en", 32'(bus_if.io_read_en), 32'h0);
    chk("t2_wdata", bus_if.io_write_data, 32'hcafe);
    chk("t2_address", bus_if.io_address, 32'h20);
    step();
    man_ack = 1'b0;
    @(negedge clk);
    chk("t2_rsp_valid_n2", 32'(bus_if.ii_response_valid), 32'h1);
    chk("t2_write_en_off", 32'(bus_if.io_write_en), 32'h0);
    chk("t2_rsp_value", bus_if.ii_response.read_value, 32'h0);
    chk("t2_rsp_core", 32'(bus_if.ii_response.core), 32'd0);
    step();
    chk("t2_wr_cycles", 32'(wr_cycles - wr0), 32'd1);

    // Test 3: all cores requesting, immediate ack, from fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h1000 + 32'(i), 32'h0, 2'(i));
    auto_ack = 1'b1;
    bus_if.ior_request_valid = 4'b1111;
    snap();
    repeat (15) step();
    bus_if.ior_request_valid = '0;
    repeat (3) step();
    chk("t3_grant_count", 32'(grant_n - g0), 32'd5);
    chk("t3_grant0", 32'(grant_log[g0]),     32'd0);
    chk("t3_grant1", 32'(grant_log[g0 + 1]), 32'd1);
    chk("t3_grant2", 32'(grant_log[g0 + 2]), 32'd2);
    chk("t3_grant3", 32'(grant_log[g0 + 3]), 32'd3);
    chk("t3_grant4", 32'(grant_log[g0 + 4]), 32'd0);
    chk("t3_rsp_count", 32'(rsp_cnt - rsp0), 32'd5);
    chk("t3_multi_ready", 32'(multi_ready), 32'd0);
    chk("t3_grant_overlap", 32'(overlap), 32'd0);

    // Test 4: load with no ack times out after 8 strobe cycles
    auto_ack = 1'b0;
    set_req(1, 1'b0, 32'h40, 32'h0, 2'd3);
    bus_if.ior_request_valid = 4'b0010;
    snap();
    step();
    bus_if.ior_request_valid = '0;
    repeat (12) step();
    chk("t4_rd_cycles", 32'(rd_cycles - rd0), 32'd8);
    chk("t4_rsp_count", 32'(rsp_cnt - rsp0), 32'd1);
    chk("t4_rsp_value", last_rsp.read_value, 32'hffffffff);
    chk("t4_rsp_core", 32'(last_rsp.core), 32'd1);
    chk("t4_rsp_thread", 32'(last_rsp.thread_idx), 32'd3);
    auto_ack = 1'b1;
    set_req(3, 1'b1, 32'h44, 32'h55, 2'd0);
    bus_if.ior_request_valid = 4'b1000;
    snap();
    step();
    bus_if.ior_request_valid = '0;
    repeat (4) step();
    chk("t4_next_rsp_count", 32'(rsp_cnt - rsp0), 32'd1);
    chk("t4_next_rsp_core", 32'(last_rsp.core), 32'd3);
    chk("t4_next_rsp_value", last_rsp.read_value, 32'h0);

    // Test 5: reset two cycles into the bus phase
    auto_ack = 1'b0;
    set_req(2, 1'b0, 32'h200, 32'h0, 2'd0);
    bus_if.ior_request_valid = 4'b0100;
    snap();
    step();
    bus_if.ior_request_valid = '0;
    step();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_strobes_async", {30'h0, bus_if.io_write_en, bus_if.io_read_en}, 32'h0);
    chk("t5_rsp_valid_async", 32'(bus_if.ii_response_valid), 32'h0);
    repeat (2) step();
    reset = 1'b0;
    set_req(0, 1'b0, 32'h300, 32'h0, 2'd2);
    set_req(1, 1'b0, 32'h304, 32'h0, 2'd2);
    set_req(3, 1'b0, 32'h30c, 32'h0, 2'd2);
    bus_if.ior_request_valid = 4'b1011;
    @(negedge clk);
    chk("t5_ready_core0", 32'(bus_if.ii_ready), 32'h1);
    step();
    bus_if.ior_request_valid = '0;
    auto_ack = 1'b1;
    repeat (4) step();
    chk("t5_rsp_count", 32'(rsp_cnt - rsp0), 32'd1);
    chk("t5_rsp_core", 32'(last_rsp.core), 32'd0);

    // Test 6: spurious ack while idle
    auto_ack = 1'b0;
    snap();
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid", 32'(bus_if.ii_response_valid), 32'h0);
    chk("t6_strobes", {30'h0, bus_if.io_write_en, bus_if.io_read_en}, 32'h0);
    step();
    set_req(1, 1'b0, 32'h400, 32'h0, 2'd1);
    bus_if.ior_request_valid = 4'b0010;
    @(negedge clk);
    chk("t6_still_idle_ready", 32'(bus_if.ii_ready), 32'h2);
    step();
    bus_if.ior_request_valid = '0;
    auto_ack = 1'b1;
    repeat (4) step();
    chk("t6_rsp_count", 32'(rsp_cnt - rsp0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
